traffic_lights_cmd_gen: RTL and testbench
=========================================

# traffic_lights_cmd_gen

Command initiator for the `traffic_lights` command port. It accepts host requests on a valid/ready interface and issues single-cycle `cmd_type`/`cmd_valid`/`cmd_data` pulses with a guaranteed idle gap between them. It tracks the controller mode and inserts an "uncontrolled" command ahead of any time-setting request issued outside that mode. It sits between a host/register block and `traffic_lights`, and drives that block's command inputs directly.

## Interface
- `GAP_TICKS`, 2: minimum number of idle cycles between consecutive `cmd_valid_o` pulses (0..255).
- `clk_i`  in  1  clock.
- `srst_i`  in  1  synchronous reset, active-high.
- `req_type_i`  in  3  requested command.
  - 0 = on; 1 = off; 2 = uncontrolled (yellow blink).
  - 3 = set green ms; 4 = set red ms; 5 = set yellow ms.
  - 6 and 7 are illegal.
- `req_data_i`  in  16  time in ms; used only by types 3..5.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request this cycle.
- `cmd_type_o`  out  3  command type to `traffic_lights`.
- `cmd_valid_o`  out  1  single-cycle command strobe.
- `cmd_data_o`  out  16  command data.
- `mode_o`  out  2  tracked mode: 0 = ON, 1 = OFF, 2 = UNCTRL.
- `err_o`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, PRE, PRE_GAP, ISSUE, GAP.
- `req_ready_o` = (state == IDLE) and not `srst_i`. A request is accepted when `req_valid_i` and `req_ready_o` are both 1.
- Reset values: `req_ready_o` 0 while `srst_i` is high, 1 in the first cycle after reset. `cmd_valid_o` 0, `cmd_type_o` 0, `cmd_data_o` 0, `err_o` 0, `mode_o` ON. State IDLE.
- Accepted illegal request (type 6/7, or type 3..5 with data 0):
  - Request is consumed and no command is issued.
  - `err_o` = 1 in the next cycle.
  - State stays IDLE.
- Accepted type 0..2, or type 3..5 while `mode_o` == UNCTRL: latch the type and data, go to ISSUE.
- Accepted type 3..5 while `mode_o` != UNCTRL: latch the type and data, go to PRE.
- PRE: drive `cmd_valid_o` = 1, `cmd_type_o` = 2, `cmd_data_o` = 0. Set `mode_o` = UNCTRL. Go to PRE_GAP.
- PRE_GAP: wait `GAP_TICKS` cycles, then go to ISSUE. With `GAP_TICKS` = 0 it is skipped, so ISSUE directly follows PRE.
- ISSUE: drive `cmd_valid_o` = 1 with the latched type.
  - `cmd_data_o` = latched data for types 3..5, 0 otherwise.
  - Types 0/1/2 update `mode_o` to ON/OFF/UNCTRL in the same cycle.
  - Go to GAP.
- GAP: `GAP_TICKS` idle cycles, then IDLE. With `GAP_TICKS` = 0, ISSUE returns straight to IDLE.
- When `cmd_valid_o` is 0, `cmd_type_o` and `cmd_data_o` are 0.
- `req_type_i` 2 while already UNCTRL is issued normally; there is no suppression.
- All outputs are registered. No combinational path from `req_*` to `cmd_*`.

## Timing
- Request accepted in cycle N, no insert:
  - `cmd_valid_o` high in N+1.
  - `req_ready_o` high again in N+2+`GAP_TICKS`.
- Request accepted in cycle N, with insert:
  - Type-2 strobe in N+1.
  - Set strobe in N+2+`GAP_TICKS`.
  - `req_ready_o` high in N+3+2·`GAP_TICKS`.
- Illegal request accepted in cycle N: `err_o` high in N+1. `req_ready_o` stays high, so a new request can be accepted in N+1.
- Strobes are never back-to-back when `GAP_TICKS` ≥ 1. Every strobe lasts exactly 1 cycle.
- `srst_i` high in any state:
  - Outputs take reset values in the next cycle.
  - The pending latched request, including a set command waiting behind PRE, is dropped.
  - `mode_o` returns to ON.
- `req_valid_i` while not ready: ignored. The host must hold the request; the block does not latch it.

## Test plan
- Reset, then type 0 request at cycle 5 with `GAP_TICKS` = 2 -> one strobe with type 0 and data 0 at cycle 6; ready low cycles 6..8, high at 9; `mode_o` stays ON.
- Type 4 with data 1500 from mode ON at cycle 10, `GAP_TICKS` = 2 -> strobe type 2 at 11 with `mode_o` UNCTRL from 11; strobe type 4 with data 1500 at 14; ready at 17.
- Type 3 with data 800 while UNCTRL -> single strobe type 3 with data 800, no insert; mode unchanged.
- Type 7, then type 5 with data 0 -> `err_o` pulse after each, no `cmd_valid_o`, ready stays 1.
- Reset asserted in PRE_GAP after the type-2 strobe of an inserted type-5 request -> no type-5 strobe; `mode_o` ON, ready 1 the cycle after reset deasserts.
- `GAP_TICKS` = 0, continuous type 1 / type 0 requests -> a strobe every 2 cycles, `mode_o` alternating OFF/ON.

Source files
------------

// File: rtl/traffic_lights_cmd_gen_if.sv
// ----------------------------------------------------------------------------
// traffic_lights_cmd_gen_if
//   Bundles the host request channel and the outgoing command strobe of
//   traffic_lights_cmd_gen.
//
//   Request channel (valid/ready): the host drives req_type/req_data and
//   raises req_valid, then holds all three unchanged until it sees req_ready
//   high in the same cycle. The request is consumed on that clock edge. The
//   command generator never stores a request it did not accept.
//
//   Command channel: cmd_valid is a one-cycle strobe with no back-pressure.
//   cmd_type/cmd_data are meaningful only while cmd_valid is high and read 0
//   otherwise.
//
//   Modports:
//     slave  - command generator side (consumes requests, drives commands)
//     master - host side (drives requests, observes commands)
// ----------------------------------------------------------------------------
interface traffic_lights_cmd_gen_if;
  logic [2:0]  req_type;
  logic [15:0] req_data;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  cmd_type;
  logic        cmd_valid;
  logic [15:0] cmd_data;

  modport slave (
    input  req_type, req_data, req_valid,
    output req_ready, cmd_type, cmd_valid, cmd_data
  );

  modport master (
    output req_type, req_data, req_valid,
    input  req_ready, cmd_type, cmd_valid, cmd_data
  );
endinterface

// File: rtl/traffic_lights_cmd_gen.sv
// ----------------------------------------------------------------------------
// traffic_lights_cmd_gen
//   Turns host requests into single-cycle command strobes for traffic_lights,
//   keeping at least GAP_TICKS idle cycles between strobes. It tracks the
//   controller mode and, when a time-setting request (types 3..5) arrives
//   outside UNCTRL, first issues an "uncontrolled" (type 2) strobe.
//
//   Ports:
//     clk_i    - clock
//     srst_i   - synchronous reset, active-high
//     bus      - request channel + command strobe (slave modport)
//     mode_o   - tracked mode: 0 = ON, 1 = OFF, 2 = UNCTRL
//     err_o    - one-cycle pulse after an illegal request is consumed
//     state_o  - current FSM state (debug visibility)
// ----------------------------------------------------------------------------
module traffic_lights_cmd_gen #(
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                            clk_i,
  input  logic                            srst_i,
  traffic_lights_cmd_gen_if.slave         bus,
  output logic [1:0]                      mode_o,
  output logic                            err_o,
  output logic [2:0]                      state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_PRE_GAP = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  localparam logic [1:0] MODE_ON     = 2'd0;
  localparam logic [1:0] MODE_UNCTRL = 2'd2;

  // Gap counters are loaded with the last index so a wait of N cycles ends
  // when the counter reaches zero.
  localparam logic [7:0] GAP_LAST = (GAP_TICKS == 0) ? 8'd0 : 8'(GAP_TICKS - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  lat_type_q, lat_type_d;
  logic [15:0] lat_data_q, lat_data_d;
  logic [1:0]  mode_q, mode_d;
  logic        err_q, err_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [2:0]  cmd_type_q, cmd_type_d;
  logic [15:0] cmd_data_q, cmd_data_d;

  logic        req_is_set;
  logic        req_illegal;
  logic        issue_now;
  logic [2:0]  issue_type;
  logic [15:0] issue_data;

  assign req_is_set  = (bus.req_type >= 3'd3) && (bus.req_type <= 3'd5);
  assign req_illegal = (bus.req_type[2:1] == 2'b11) ||
                       (req_is_set && (bus.req_data == 16'd0));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_type_d  = lat_type_q;
    lat_data_d  = lat_data_q;
    mode_d      = mode_q;
    err_d       = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_type_d  = 3'd0;
    cmd_data_d  = 16'd0;
    issue_now   = 1'b0;
    issue_type  = lat_type_q;
    issue_data  = lat_data_q;

    case (state_q)
      ST_IDLE: begin
        // Reset forces IDLE on the next edge, so ready's srst_i term does
        // not need repeating here.
        if (bus.req_valid) begin
          if (req_illegal) begin
            err_d = 1'b1;
          end else begin
            lat_type_d = bus.req_type;
            lat_data_d = bus.req_data;
            if (req_is_set && (mode_q != MODE_UNCTRL)) begin
              state_d     = ST_PRE;
              cmd_valid_d = 1'b1;
              cmd_type_d  = 3'd2;
              mode_d      = MODE_UNCTRL;
            end else begin
              issue_now  = 1'b1;
              issue_type = bus.req_type;
              issue_data = bus.req_data;
            end
          end
        end
      end
      ST_PRE: begin
        if (GAP_TICKS == 0) begin
          issue_now = 1'b1;
        end else begin
          state_d = ST_PRE_GAP;
          cnt_d   = GAP_LAST;
        end
      end
      ST_PRE_GAP: begin
        if (cnt_q == 8'd0) issue_now = 1'b1;
        else               cnt_d     = cnt_q - 8'd1;
      end
      ST_ISSUE: begin
        if (GAP_TICKS == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The strobe for the real command is registered on entry to ISSUE so it
    // is visible during the ISSUE cycle itself.
    if (issue_now) begin
      state_d     = ST_ISSUE;
      cmd_valid_d = 1'b1;
      cmd_type_d  = issue_type;
      cmd_data_d  = (issue_type >= 3'd3) ? issue_data : 16'd0;
      if (issue_type <= 3'd2) mode_d = issue_type[1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      lat_type_q  <= 3'd0;
      lat_data_q  <= 16'd0;
      mode_q      <= MODE_ON;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 3'd0;
      cmd_data_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_type_q  <= lat_type_d;
      lat_data_q  <= lat_data_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) && !srst_i;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.cmd_data  = cmd_data_q;
  assign mode_o        = mode_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_traffic_lights_cmd_gen.sv
// ----------------------------------------------------------------------------
// tb_traffic_lights_cmd_gen
//   Two instances: dut0 with GAP_TICKS = 2, dut1 with GAP_TICKS = 0.
//   A transaction-level reference model predicts, per accepted request, the
//   cycles of each strobe, the mode change, the error pulse and when ready
//   returns; every cycle the DUT outputs are compared against it.
// ----------------------------------------------------------------------------
module tb_traffic_lights_cmd_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- DUT wiring ----------------
  logic [2:0]  d_type  [2];
  logic [15:0] d_data  [2];
  logic        d_valid [2];
  logic        o_ready [2];
  logic        o_valid [2];
  logic        o_err   [2];
  logic [2:0]  o_type  [2];
  logic [2:0]  o_state [2];
  logic [15:0] o_data  [2];
  logic [1:0]  o_mode  [2];

  traffic_lights_cmd_gen_if bus0 ();
  traffic_lights_cmd_gen_if bus1 ();

  assign bus0.req_type  = d_type[0];
  assign bus0.req_data  = d_data[0];
  assign bus0.req_valid = d_valid[0];
  assign o_ready[0]     = bus0.req_ready;
  assign o_valid[0]     = bus0.cmd_valid;
  assign o_type[0]      = bus0.cmd_type;
  assign o_data[0]      = bus0.cmd_data;

  assign bus1.req_type  = d_type[1];
  assign bus1.req_data  = d_data[1];
  assign bus1.req_valid = d_valid[1];
  assign o_ready[1]     = bus1.req_ready;
  assign o_valid[1]     = bus1.cmd_valid;
  assign o_type[1]      = bus1.cmd_type;
  assign o_data[1]      = bus1.cmd_data;

  traffic_lights_cmd_gen #(.GAP_TICKS(2)) dut0 (
    .clk_i(clk), .srst_i(rst), .bus(bus0),
    .mode_o(o_mode[0]), .err_o(o_err[0]), .state_o(o_state[0])
  );

  traffic_lights_cmd_gen #(.GAP_TICKS(0)) dut1 (
    .clk_i(clk), .srst_i(rst), .bus(bus1),
    .mode_o(o_mode[1]), .err_o(o_err[1]), .state_o(o_state[1])
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          k;
    int          c;
    logic [2:0]  t;
    logic [15:0] d;
  } strobe_t;

  strobe_t     exp_q[$];
  int          busy_until [2] = '{0, 0};
  int          err_cyc    [2] = '{-1, -1};
  int          pm_cyc     [2] = '{-1, -1};
  logic [1:0]  pm_val     [2] = '{2'd0, 2'd0};
  logic [1:0]  exp_mode   [2] = '{2'd0, 2'd0};
  int          seen_strb  [2] = '{0, 0};
  int          seen_errs  [2] = '{0, 0};
  logic [2:0]  last_t     [2] = '{3'd0, 3'd0};
  logic [15:0] last_d     [2] = '{16'd0, 16'd0};
  bit          chk_en = 1'b0;

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic push_strobe(input int k, input int c, input logic [2:0] t, input logic [15:0] d);
    strobe_t s;
    s.k = k; s.c = c; s.t = t; s.d = d;
    exp_q.push_back(s);
  endtask

  task automatic model_step(input int k);
    int          c, g;
    logic        ev, er, rd;
    logic [2:0]  et, t;
    logic [15:0] ed, d;
    c = cyc;
    g = gap_of(k);
    if (pm_cyc[k] == c) exp_mode[k] = pm_val[k];
    ev = 1'b0; et = 3'd0; ed = 16'd0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].k == k) begin
        if (exp_q[i].c == c) begin
          ev = 1'b1; et = exp_q[i].t; ed = exp_q[i].d;
          exp_q.delete(i);
        end
        break;
      end
    end
    er = (err_cyc[k] == c);
    rd = !rst && (c >= busy_until[k]);

    check("req_ready", k, 32'(o_ready[k]), 32'(rd));
    check("cmd_valid", k, 32'(o_valid[k]), 32'(ev));
    check("cmd_type",  k, 32'(o_type[k]),  32'(et));
    check("cmd_data",  k, 32'(o_data[k]),  32'(ed));
    check("mode",      k, 32'(o_mode[k]),  32'(exp_mode[k]));
    check("err",       k, 32'(o_err[k]),   32'(er));

    if (o_valid[k] === 1'b1) begin
      seen_strb[k]++;
      last_t[k] = o_type[k];
      last_d[k] = o_data[k];
    end
    if (o_err[k] === 1'b1) seen_errs[k]++;

    if (rst) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].k == k) exp_q.delete(i);
      pm_cyc[k]     = -1;
      err_cyc[k]    = -1;
      busy_until[k] = c + 1;
      exp_mode[k]   = 2'd0;
    end else if (d_valid[k] && rd) begin
      t = d_type[k];
      d = d_data[k];
      if (t >= 6 || (t >= 3 && d == 16'd0)) begin
        err_cyc[k] = c + 1;
      end else if (t >= 3 && exp_mode[k] != 2'd2) begin
        push_strobe(k, c + 1, 3'd2, 16'd0);
        push_strobe(k, c + 2 + g, t, d);
        pm_cyc[k]     = c + 1;
        pm_val[k]     = 2'd2;
        busy_until[k] = c + 3 + 2 * g;
      end else begin
        push_strobe(k, c + 1, t, (t >= 3) ? d : 16'd0);
        if (t <= 2) begin
          pm_cyc[k] = c + 1;
          pm_val[k] = t[1:0];
        end
        busy_until[k] = c + 2 + g;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic send(input int k, input logic [2:0] t, input logic [15:0] d);
    int n;
    n = 0;
    d_type[k]  = t;
    d_data[k]  = d;
    d_valid[k] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (o_ready[k] !== 1'b1 && n < 64);
    if (n >= 64) check("accept_timeout", k, 32'd0, 32'd1);
    @(posedge clk); #1;
    d_valid[k] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offset i (1..n) after acceptance: bit i of vp/rp gives expected valid/ready.
  task automatic check_window(input int k, input int n, input logic [15:0] vp,
                              input logic [15:0] rp, input string name);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check({name, "_valid"}, k, 32'(o_valid[k]), 32'(vp[i]));
      check({name, "_ready"}, k, 32'(o_ready[k]), 32'(rp[i]));
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  t;
    logic [15:0] d;
    int          n_strb;
    int          n_err;
    logic [1:0]  mode;
    logic [2:0]  lt;
    logic [15:0] ld;
  } vec_t;

  vec_t vecs [10];

  // ---------------- main ----------------
  initial begin
    int s0, e0, c_prev, c_now;
    for (int k = 0; k < 2; k++) begin
      d_type[k] = 3'd0; d_data[k] = 16'd0; d_valid[k] = 1'b0;
    end

    // Entered from mode UNCTRL (left there by the insert sequence).
    vecs[0] = '{3'd3, 16'd800,   1, 0, 2'd2, 3'd3, 16'd800};
    vecs[1] = '{3'd7, 16'd5,     0, 1, 2'd2, 3'd0, 16'd0};
    vecs[2] = '{3'd5, 16'd0,     0, 1, 2'd2, 3'd0, 16'd0};
    vecs[3] = '{3'd2, 16'd9,     1, 0, 2'd2, 3'd2, 16'd0};
    vecs[4] = '{3'd1, 16'd7,     1, 0, 2'd1, 3'd1, 16'd0};
    vecs[5] = '{3'd5, 16'd65535, 2, 0, 2'd2, 3'd5, 16'd65535};
    vecs[6] = '{3'd0, 16'd3,     1, 0, 2'd0, 3'd0, 16'd0};
    vecs[7] = '{3'd6, 16'd0,     0, 1, 2'd0, 3'd0, 16'd0};
    vecs[8] = '{3'd3, 16'd1,     2, 0, 2'd2, 3'd3, 16'd1};
    vecs[9] = '{3'd4, 16'd2,     1, 0, 2'd2, 3'd4, 16'd2};

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          model_step(0);
          model_step(1);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state, first cycle after reset
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", k, 32'(o_ready[k]), 32'd1);
      check("rst_valid", k, 32'(o_valid[k]), 32'd0);
      check("rst_mode",  k, 32'(o_mode[k]),  32'd0);
      check("rst_err",   k, 32'(o_err[k]),   32'd0);
    end
    @(posedge clk); #1;

    // Plain command, GAP 2: strobe at +1, ready back at +4
    idle(2);
    send(0, 3'd0, 16'd0);
    check_window(0, 4, 16'b0000_0000_0000_0010, 16'b0000_0000_0001_0000, "plain");
    check("plain_mode", 0, 32'(o_mode[0]), 32'd0);
    check("plain_type", 0, 32'(last_t[0]), 32'd0);

    // Set from ON, GAP 2: type-2 at +1, set at +4, ready at +7
    send(0, 3'd4, 16'd1500);
    check_window(0, 7, 16'b0000_0000_0001_0010, 16'b0000_0000_1000_0000, "insert");
    check("insert_type", 0, 32'(last_t[0]), 32'd4);
    check("insert_data", 0, 32'(last_d[0]), 32'd1500);
    check("insert_mode", 0, 32'(o_mode[0]), 32'd2);

    // Table-driven requests on dut0
    for (int i = 0; i < 10; i++) begin
      s0 = seen_strb[0];
      e0 = seen_errs[0];
      send(0, vecs[i].t, vecs[i].d);
      idle(10);
      check($sformatf("vec%0d_strobes", i), 0, 32'(seen_strb[0] - s0), 32'(vecs[i].n_strb));
      check($sformatf("vec%0d_errs", i),    0, 32'(seen_errs[0] - e0), 32'(vecs[i].n_err));
      check($sformatf("vec%0d_mode", i),    0, 32'(o_mode[0]),         32'(vecs[i].mode));
      if (vecs[i].n_strb > 0) begin
        check($sformatf("vec%0d_type", i), 0, 32'(last_t[0]), 32'(vecs[i].lt));
        check($sformatf("vec%0d_data", i), 0, 32'(last_d[0]), 32'(vecs[i].ld));
      end
    end

    // Two illegal requests back to back: second accepted one cycle later
    s0 = seen_strb[0];
    send(0, 3'd7, 16'd1);
    c_prev = cyc;
    send(0, 3'd5, 16'd0);
    c_now = cyc;
    check("illegal_b2b_spacing", 0, 32'(c_now - c_prev), 32'd1);
    idle(4);
    check("illegal_no_strobe", 0, 32'(seen_strb[0] - s0), 32'd0);

    // Reset while the inserted set command waits in PRE_GAP
    send(0, 3'd0, 16'd0);
    idle(4);
    send(0, 3'd5, 16'd100);
    @(posedge clk); #1;
    pulse_reset();
    s0 = seen_strb[0];
    @(negedge clk);
    check("rst_pregap_ready", 0, 32'(o_ready[0]), 32'd1);
    check("rst_pregap_mode",  0, 32'(o_mode[0]),  32'd0);
    @(posedge clk); #1;
    idle(8);
    check("rst_pregap_dropped", 0, 32'(seen_strb[0] - s0), 32'd0);

    // GAP 0: continuous off/on requests, one strobe every 2 cycles
    c_prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(1, (i % 2 == 0) ? 3'd1 : 3'd0, 16'd0);
      c_now = cyc;
      check($sformatf("gap0_mode%0d", i), 1, 32'(o_mode[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i > 0) check($sformatf("gap0_spacing%0d", i), 1, 32'(c_now - c_prev), 32'd2);
      c_prev = c_now;
    end
    idle(4);

    // Random traffic on both instances, with occasional resets
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 200; i++) begin
        logic [2:0]  t;
        logic [15:0] d;
        t = 3'($urandom_range(0, 7));
        d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        send(k, t, d);
        if ($urandom_range(0, 24) == 0) begin
          idle($urandom_range(0, 5));
          pulse_reset();
        end
        idle($urandom_range(0, 3));
      end
      idle(10);
    end

    idle(4);
    check("model_queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
